// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder.
interface pipelined_cla_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    // Producer/consumer side driving operands and taking results.
    modport master (
        output a, b, cin, sub, in_valid, out_ready,
        input  in_ready, sum, ovf, out_valid
    );

    // Adder side.
    modport slave (
        input  a, b, cin, sub, in_valid, out_ready,
        output in_ready, sum, ovf, out_valid
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group
// resolved per stage, group carry registered between stages, valid/ready flow.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input logic                  clk,
    input logic                  rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / GROUP;

    // Carries into every bit of one group, each a flat sum of G/P products (no ripple).
    function automatic logic [GROUP:0] cla_carries(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             c_in
    );
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        term = 1'b0;
        c[0] = c_in;
        for (int i = 1; i <= int'(GROUP); i++) begin
            term = c_in;
            for (int j = 0; j < i; j++) term = term & p[j];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  a_d     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  b_d     [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic              ovf_q;
    logic              ovf_d;

    logic [WIDTH-1:0]  st_a    [STAGES];
    logic [WIDTH-1:0]  st_b    [STAGES];
    logic [WIDTH-1:0]  st_s    [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_v;
    logic [GROUP:0]    grp_c   [STAGES];
    logic [GROUP-1:0]  grp_g;
    logic [GROUP-1:0]  grp_p;
    logic              advance_c;

    // Whole pipe moves together unless the output holds an unconsumed result.
    assign advance_c     = ~valid_q[STAGES-1] | bus.out_ready;
    assign bus.in_ready  = advance_c;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = {carry_q[STAGES-1], sum_q[STAGES-1]};
    assign bus.ovf       = ovf_q;

    // Per-stage next values: stage k resolves group k from the carry handed down by stage k-1.
    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            st_a[k]  = '0;
            st_b[k]  = '0;
            st_s[k]  = '0;
            a_d[k]   = '0;
            b_d[k]   = '0;
            sum_d[k] = '0;
            grp_c[k] = '0;
        end
        st_c    = '0;
        st_v    = '0;
        valid_d = '0;
        carry_d = '0;
        grp_g   = '0;
        grp_p   = '0;
        ovf_d   = 1'b0;

        // Subtraction is A + ~B + ~borrow; the carry out then reads as "no borrow".
        st_a[0] = bus.a;
        st_b[0] = bus.sub ? ~bus.b : bus.b;
        st_c[0] = bus.sub ? ~bus.cin : bus.cin;
        st_v[0] = bus.in_valid & advance_c;
        for (int k = 1; k < int'(STAGES); k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_s[k] = sum_q[k-1];
            st_c[k] = carry_q[k-1];
            st_v[k] = valid_q[k-1];
        end

        for (int k = 0; k < int'(STAGES); k++) begin
            grp_g    = st_a[k][k*GROUP +: GROUP] & st_b[k][k*GROUP +: GROUP];
            grp_p    = st_a[k][k*GROUP +: GROUP] ^ st_b[k][k*GROUP +: GROUP];
            grp_c[k] = cla_carries(grp_g, grp_p, st_c[k]);
            sum_d[k] = st_s[k];
            sum_d[k][k*GROUP +: GROUP] = grp_p ^ grp_c[k][GROUP-1:0];
            carry_d[k] = grp_c[k][GROUP];
            a_d[k]     = st_a[k];
            b_d[k]     = st_b[k];
            valid_d[k] = st_v[k];
        end

        // Signed overflow: carry into the MSB differs from carry out of it.
        ovf_d = grp_c[STAGES-1][GROUP] ^ grp_c[STAGES-1][GROUP-1];
    end

    // Stage registers: valid bits shift on every advance, payload only loads with a real beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
            carry_q <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
        end else if (advance_c) begin
            valid_q <= valid_d;
            for (int k = 0; k < int'(STAGES); k++) begin
                if (valid_d[k]) begin
                    a_q[k]     <= a_d[k];
                    b_q[k]     <= b_d[k];
                    sum_q[k]   <= sum_d[k];
                    carry_q[k] <= carry_d[k];
                end
            end
            if (valid_d[STAGES-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: a 4-bit single-stage and a 16-bit four-stage
// instance checked against an arithmetic model of add/sub with carry and overflow.
module tb_pipelined_cla_adder;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    typedef struct packed {
        logic [16:0] sum;
        logic        ovf;
    } exp_t;

    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
    pipelined_cla_adder_if #(.WIDTH(4))  bus4  ();

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    pipelined_cla_adder #(.WIDTH(4),  .GROUP(4)) dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

    // Model: add gives A+B+cin; sub gives A-B-cin offset by 2^w so the top bit means "no borrow".
    function automatic longint ref_sum(int w, longint a, longint b, bit cin, bit sub);
        if (sub) return a - b - longint'(cin) + (longint'(1) << w);
        return a + b + longint'(cin);
    endfunction

    // Model: true signed result falls outside the w-bit two's-complement range.
    function automatic bit ref_ovf(int w, longint a, longint b, bit cin, bit sub);
        longint half = longint'(1) << (w - 1);
        longint full = longint'(1) << w;
        longint sa   = (a >= half) ? a - full : a;
        longint sb   = (b >= half) ? b - full : b;
        longint r    = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
        return (r < -half) || (r >= half);
    endfunction

    function automatic exp_t ref16(logic [15:0] a, logic [15:0] b, bit cin, bit sub);
        exp_t e;
        e.sum = 17'(ref_sum(16, longint'(a), longint'(b), cin, sub));
        e.ovf = ref_ovf(16, longint'(a), longint'(b), cin, sub);
        return e;
    endfunction

    // Push one beat into the empty 16-bit pipe and report latency and result.
    task automatic run_one16(input logic [15:0] a, input logic [15:0] b, input bit cin, input bit sub,
                             output logic [16:0] s, output logic o, output int lat);
        bit done = 1'b0;
        bus16.out_ready = 1'b1;
        bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = -1; s = 'x; o = 1'bx;
        for (int n = 0; n < 20; n++) begin
            if (!done) begin
                if (bus16.out_valid === 1'b1) begin
                    done = 1'b1; lat = n; s = bus16.sum; o = bus16.ovf;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus16.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid16 got=%b want=0", bus16.out_valid); end
        total++; if (bus16.sum !== 17'h0) begin bad++; $display("FAIL reset_sum16 got=%h want=0", bus16.sum); end
        total++; if (bus16.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf16 got=%b want=0", bus16.ovf); end
        total++; if (bus16.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready16 got=%b want=1", bus16.in_ready); end
        total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid4 got=%b want=0", bus4.out_valid); end
        total++; if (bus4.sum !== 5'h0) begin bad++; $display("FAIL reset_sum4 got=%h want=0", bus4.sum); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive4();
        logic [4:0] es;
        bit         eo;
        bus4.out_ready = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++) begin
                        bus4.a = 4'(a); bus4.b = 4'(b); bus4.cin = c[0]; bus4.sub = s[0];
                        bus4.in_valid = 1'b1;
                        es = 5'(ref_sum(4, longint'(a), longint'(b), c[0], s[0]));
                        eo = ref_ovf(4, longint'(a), longint'(b), c[0], s[0]);
                        @(posedge clk); #1;
                        total++; if (bus4.out_valid !== 1'b1) begin bad++; $display("FAIL w4_valid a=%0d b=%0d got=%b want=1", a, b, bus4.out_valid); end
                        total++; if (bus4.sum !== es) begin bad++; $display("FAIL w4_sum a=%0d b=%0d cin=%0d sub=%0d got=%h want=%h", a, b, c, s, bus4.sum, es); end
                        total++; if (bus4.ovf !== eo) begin bad++; $display("FAIL w4_ovf a=%0d b=%0d cin=%0d sub=%0d got=%b want=%b", a, b, c, s, bus4.ovf, eo); end
                    end
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL w4_drain got=%b want=0", bus4.out_valid); end
    endtask

    task automatic test_latency16();
        logic [16:0] s; logic o; int lat;
        run_one16(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, o, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL lat16 got=%0d want=3", lat); end
        total++; if (s !== 17'h10000) begin bad++; $display("FAIL carry_out_sum got=%h want=10000", s); end
        total++; if (o !== 1'b0) begin bad++; $display("FAIL carry_out_ovf got=%b want=0", o); end
        @(posedge clk); #1;
        total++; if (bus16.out_valid !== 1'b0) begin bad++; $display("FAIL single_no_dup got=%b want=0", bus16.out_valid); end
    endtask

    task automatic test_overflow16();
        logic [16:0] s; logic o; int lat;
        run_one16(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, o, lat);
        total++; if (s !== 17'h08000) begin bad++; $display("FAIL ovf_add_sum got=%h want=08000", s); end
        total++; if (o !== 1'b1) begin bad++; $display("FAIL ovf_add_flag got=%b want=1", o); end
        @(posedge clk); #1;
        run_one16(16'h0005, 16'h0007, 1'b0, 1'b1, s, o, lat);
        total++; if (s !== 17'h0FFFE) begin bad++; $display("FAIL borrow_sum got=%h want=0fffe", s); end
        total++; if (o !== 1'b0) begin bad++; $display("FAIL borrow_ovf got=%b want=0", o); end
        @(posedge clk); #1;
    endtask

    task automatic test_random16();
        logic [16:0] s; logic o; int lat; exp_t e;
        logic [15:0] a, b; bit c, sb;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); sb = 1'($urandom);
            e = ref16(a, b, c, sb);
            run_one16(a, b, c, sb, s, o, lat);
            total++; if (lat !== 3 || s !== e.sum || o !== e.ovf)
                begin bad++; $display("FAIL rand16 a=%h b=%h cin=%0d sub=%0d got=%h/%b/lat%0d want=%h/%b/lat3", a, b, c, sb, s, o, lat, e.sum, e.ovf); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [6];
        logic [15:0] tb_ [6];
        bit          tc [6];
        bit          ts [6];
        exp_t        q [$];
        int          sent = 0, recv = 0, stall = 0;
        bit          seen = 1'b0, acc, pop;
        for (int i = 0; i < 6; i++) begin
            ta[i] = 16'($urandom); tb_[i] = 16'($urandom); tc[i] = 1'($urandom); ts[i] = 1'($urandom);
        end
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (recv < 6) begin
                if (bus16.out_valid === 1'b1) begin
                    if (!seen) begin seen = 1'b1; stall = 3; end
                    total++;
                    if (q.size() == 0) begin
                        bad++; $display("FAIL bb_extra got=%h want=none", bus16.sum);
                    end else if (bus16.sum !== q[0].sum || bus16.ovf !== q[0].ovf) begin
                        bad++; $display("FAIL bb_data idx=%0d got=%h/%b want=%h/%b", recv, bus16.sum, bus16.ovf, q[0].sum, q[0].ovf);
                    end
                end
                bus16.out_ready = (stall == 0);
                if (sent < 6) begin
                    bus16.a = ta[sent]; bus16.b = tb_[sent]; bus16.cin = tc[sent]; bus16.sub = ts[sent];
                    bus16.in_valid = 1'b1;
                end else begin
                    bus16.in_valid = 1'b0;
                end
                #1;
                if (stall > 0) begin
                    total++; if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1)
                        begin bad++; $display("FAIL bb_stall in_ready=%b out_valid=%b want 0/1", bus16.in_ready, bus16.out_valid); end
                    stall--;
                end
                acc = bus16.in_valid && bus16.in_ready;
                pop = bus16.out_valid && bus16.out_ready;
                @(posedge clk); #1;
                if (acc) begin q.push_back(ref16(ta[sent], tb_[sent], tc[sent], ts[sent])); sent++; end
                if (pop && q.size() > 0) begin void'(q.pop_front()); recv++; end
            end
        end
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        total++; if (recv !== 6) begin bad++; $display("FAIL bb_count got=%0d want=6", recv); end
        total++; if (bus16.out_valid !== 1'b0) begin bad++; $display("FAIL bb_no_dup got=%b want=0", bus16.out_valid); end
    endtask

    task automatic test_reset_midflight();
        logic [16:0] s; logic o; int lat;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'b1; bus16.sub = 1'($urandom);
            bus16.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus16.in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (bus16.out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", bus16.out_valid); end
        rst = 1'b1;
        #1;
        total++; if (bus16.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", bus16.out_valid); end
        total++; if (bus16.sum !== 17'h0) begin bad++; $display("FAIL mid_rst_sum got=%h want=0", bus16.sum); end
        total++; if (bus16.ovf !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf got=%b want=0", bus16.ovf); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_one16(16'h1234, 16'h1111, 1'b0, 1'b0, s, o, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL post_rst_lat got=%0d want=3", lat); end
        total++; if (s !== 17'h02345) begin bad++; $display("FAIL post_rst_sum got=%h want=02345", s); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            total++; if (bus16.out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_stale cyc=%0d got=%b want=0", i, bus16.out_valid); end
        end
    endtask

    task automatic test_bubbles();
        localparam int N = 24;
        bit   vpat [N];
        exp_t q [$];
        bit   ev;
        logic [15:0] a, b; bit c, sb;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < N; i++) vpat[i] = (i % 2 == 0);
        for (int cyc = 0; cyc < N + 6; cyc++) begin
            ev = (cyc >= 4 && cyc - 4 < N) ? vpat[cyc-4] : 1'b0;
            total++; if (bus16.out_valid !== ev) begin bad++; $display("FAIL bub_valid cyc=%0d got=%b want=%b", cyc, bus16.out_valid, ev); end
            if (bus16.out_valid === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bub_extra cyc=%0d got=%h want=none", cyc, bus16.sum);
                end else begin
                    if (bus16.sum !== q[0].sum || bus16.ovf !== q[0].ovf) begin
                        bad++; $display("FAIL bub_data cyc=%0d got=%h/%b want=%h/%b", cyc, bus16.sum, bus16.ovf, q[0].sum, q[0].ovf);
                    end
                    void'(q.pop_front());
                end
            end
            if (cyc < N) begin
                a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); sb = 1'($urandom);
                bus16.a = a; bus16.b = b; bus16.cin = c; bus16.sub = sb;
                bus16.in_valid = vpat[cyc];
                if (vpat[cyc]) q.push_back(ref16(a, b, c, sb));
            end else begin
                bus16.in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        total++; if (q.size() !== 0) begin bad++; $display("FAIL bub_left got=%0d want=0", q.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
        bus4.a = '0;  bus4.b = '0;  bus4.cin = 1'b0;  bus4.sub = 1'b0;  bus4.in_valid = 1'b0;  bus4.out_ready = 1'b1;
        test_reset();
        test_exhaustive4();
        test_latency16();
        test_overflow16();
        test_random16();
        test_back_to_back();
        test_reset_midflight();
        test_bubbles();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
